unary_add_param: RTL
====================

Name: unary_add_param

Overview:
Parametrised unary (bit-stream) adder, successor to the fixed 2-input, 1-bit-lane unary adders.
- Read phase: accumulates the number of 1s arriving on N_IN serial unary input lanes into a bounded counter.
- Write phase: replays the total as a single thermometer-coded unary stream on dout, with a sticky overflow flag C and a done pulse.
- Sits between unary stream producers and downstream unary consumers in the stochastic/unary datapath.

Parameters:
N_IN, 2, number of serial unary input lanes (>=1)
CNT_W, 5, accumulator width in bits
MAX_CNT, 30, largest representable total; must satisfy 1 <= MAX_CNT <= 2^CNT_W-1

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  global enable; 0 = pause
read_or_write  input  1  0 = read/accumulate, 1 = write/emit
din  input  N_IN  one bit per unary input lane (lane 0 = old A, lane 1 = old B)
dout  output  1  registered unary output stream
C  output  1  sticky overflow flag
done  output  1  one-cycle pulse, emission complete
cnt  output  CNT_W  current accumulator value (debug/observability)

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=ACC; cnt=0, rem=0, dout=0, C=0, done=0.
  - Takes effect immediately, including mid-emission.
- All state is registered. The sum is computed at width CNT_W+clog2(N_IN+1), so there is no intermediate truncation.

- FSM ACC:
  - en=1, read_or_write=0: sum = cnt + popcount(din).
    - If sum > MAX_CNT: cnt<=MAX_CNT, C<=1 (saturate).
    - Else: cnt<=sum.
  - en=1, read_or_write=1: rem<=cnt, go to EMIT; din is ignored that cycle.
  - en=0: hold.
  - dout=0 in ACC.

- FSM EMIT:
  - en=1 and rem!=0: dout<=1, rem<=rem-1.
  - en=1 and rem==0: dout<=0, done<=1, go to DONE.
  - en=0: dout<=0, rem held. Pausing inserts 0s but never loses 1s.
  - read_or_write falls to 0: abort. dout<=0, go to ACC; cnt and C are preserved, so accumulation resumes.

- FSM DONE:
  - done<=0 after its single cycle; dout=0.
  - Stay while read_or_write=1.
  - On read_or_write=0 (en=1): cnt<=0, C<=0, go to ACC.

- Timing and latency:
  - First dout=1 appears 2 clocks after the edge that samples read_or_write=1 (edge 1: ACC->EMIT; edge 2: dout<=1).
  - With no pauses, dout is high for exactly cnt consecutive cycles.
  - done is asserted the cycle after the last 1.

- Boundary conditions:
  - cnt=0 at emit start: no 1s are emitted; done asserts after edge 2.
  - Saturation exactly at MAX_CNT does not set C; only exceeding MAX_CNT does.
  - Simultaneous overflow and en=0: en wins, no update.
  - C remains visible through EMIT and DONE.

Optional Feature:
UNARY_ADD_WRAP_EN
- Defined: in ACC, overflow wraps, cnt<=sum mod (MAX_CNT+1); C is still set sticky on any wrap.
- Undefined: saturating behaviour as above.
- All other behaviour is identical in both builds.

Test Plan:
1. Default params; din=2'b11 for 15 cycles, then 2'b01 for 1 cycle; then read_or_write=1.
   -> cnt=30 with C=1 (31 > 30); dout=1 for exactly 30 cycles starting 2 clocks after rw sampled; done pulse 1 cycle after the last 1.
2. din=2'b01 for 5 cycles, then 2'b00 for 3 cycles; emit.
   -> cnt=5, C=0; exactly 5 contiguous 1s on dout; done once.
3. cnt=6, emit; drop en for 3 cycles after the 2nd 1.
   -> dout=0 during the pause; 6 total 1s; done delayed by 3 cycles.
4. cnt=6, assert rst_n=0 after the 3rd 1.
   -> dout, C, done and cnt go to 0 immediately; after release, accumulation restarts from 0.
5. read_or_write=1 with cnt=0.
   -> dout never 1; done pulses after edge 2.
   Then drop rw -> cnt=0, C=0, state ACC.
6. Build with UNARY_ADD_WRAP_EN; din=2'b11 for 16 cycles.
   -> cnt=1 (32 mod 31), C=1; emit yields a single 1.

Source files
------------

// File: rtl/unary_add_param.sv
// unary_add_param: parametrised unary (bit-stream) adder.
// Read phase counts the 1s on N_IN serial lanes into a bounded accumulator;
// write phase replays the total as one thermometer-coded stream on dout.
// Optional build macro: UNARY_ADD_WRAP_EN (overflow wraps mod MAX_CNT+1
// instead of saturating; C is sticky in both builds).
//
// state | meaning
// ------+--------------------------------------------------------------
// ACC   | accumulate popcount(din) into cnt while en=1, read_or_write=0
// EMIT  | shift out rem ones on dout, one per enabled cycle
// DONE  | done pulsed; wait for read_or_write=0 to clear cnt/C

module unary_add_param #(
  parameter int N_IN    = 2,
  parameter int CNT_W   = 5,
  parameter int MAX_CNT = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              read_or_write,
  input  logic [N_IN-1:0]   din,
  output logic              dout,
  output logic              C,
  output logic              done,
  output logic [CNT_W-1:0]  cnt
);

  // Sum is wide enough for cnt + N_IN so the overflow test never truncates.
  localparam int SUM_W = CNT_W + $clog2(N_IN + 1);
  localparam logic [SUM_W-1:0] MAX_S = SUM_W'(MAX_CNT);
`ifdef UNARY_ADD_WRAP_EN
  localparam logic [SUM_W-1:0] MOD_S = SUM_W'(MAX_CNT + 1);
`endif

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic [CNT_W-1:0]   rem_q, rem_nxt;
  logic               dout_q, dout_nxt;
  logic               c_q, c_nxt;
  logic               done_q, done_nxt;
  logic [SUM_W-1:0]   ones;
  logic [SUM_W-1:0]   sum;

  // Population count of the input lanes and the untruncated running sum.
  always_comb begin
    ones = '0;
    for (int i = 0; i < N_IN; i++) begin
      ones = ones + SUM_W'(din[i]);
    end
    sum = SUM_W'(cnt_q) + ones;
  end

  // Next-state and next-output logic; dout and done default low each cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_q;
    rem_nxt   = rem_q;
    c_nxt     = c_q;
    dout_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      ACC: begin
        if (en) begin
          if (!read_or_write) begin
            if (sum > MAX_S) begin
`ifdef UNARY_ADD_WRAP_EN
              cnt_nxt = CNT_W'(sum % MOD_S);
`else
              cnt_nxt = CNT_W'(MAX_CNT);
`endif
              c_nxt   = 1'b1;
            end else begin
              cnt_nxt = sum[CNT_W-1:0];
            end
          end else begin
            // din is ignored on the cycle that launches emission.
            rem_nxt   = cnt_q;
            state_nxt = EMIT;
          end
        end
      end
      EMIT: begin
        // Abort has priority: cnt and C are kept so accumulation resumes.
        if (!read_or_write) begin
          state_nxt = ACC;
        end else if (en) begin
          if (rem_q != '0) begin
            dout_nxt = 1'b1;
            rem_nxt  = rem_q - CNT_W'(1);
          end else begin
            done_nxt  = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (en && !read_or_write) begin
          cnt_nxt   = '0;
          c_nxt     = 1'b0;
          state_nxt = ACC;
        end
      end
      default: begin
        state_nxt = ACC;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ACC;
      cnt_q  <= '0;
      rem_q  <= '0;
      dout_q <= 1'b0;
      c_q    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt_q  <= cnt_nxt;
      rem_q  <= rem_nxt;
      dout_q <= dout_nxt;
      c_q    <= c_nxt;
      done_q <= done_nxt;
    end
  end

  assign dout = dout_q;
  assign C    = c_q;
  assign done = done_q;
  assign cnt  = cnt_q;

endmodule
